// File: rtl/ks_pkg.sv
// Karplus-Strong pluck controller shared types.
// State enum, LFSR constants and step helper.
package ks_pkg;

  localparam int DW_DEF = 16;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RING
  } state_e;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

  function automatic logic [15:0] fix_seed(
    input logic [15:0] s
  );
    return (s == 16'h0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/ks_lfsr16.sv
// 16-bit right-shifting Galois LFSR.
// Advances once per enable; an all-zero seed is remapped.
module ks_lfsr16
  import ks_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] state_o
);

  localparam logic [15:0] SEED_OK = fix_seed(SEED);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d  = lfsr_step(lfsr_q);
  assign state_o = lfsr_q;

  // shift register, stepped on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_OK;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/ks_pluck_ctrl.sv
// Karplus-Strong excitation and feedback controller.
// Noise burst for one line length, then damped two-tap feedback.
module ks_pluck_ctrl
  import ks_pkg::*;
#(
  parameter int          DW          = DW_DEF,
  parameter int          DELAY_LEN   = 328,
  parameter int          CLK_DIV     = 1024,
  parameter int          DECAY_SHIFT = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          m_clk,
  input  logic          sclr_n,
  input  logic          pluck,
  input  logic          mute,
  input  logic [3:0]    atten,
  input  logic [DW-1:0] q,
  output logic          sample_en,
  output logic [DW-1:0] dnoise,
  output logic [DW-1:0] dfilter,
  output logic          trigger,
  output logic          busy
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW   = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DELAY_LEN - 1);

  logic [DIVW-1:0] div_q;
  logic            tick;
  logic            sample_en_q;
  logic            pend_q;
  logic            pend_now;
  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic            trigger_q;
  logic            busy_q;
  logic [DW-1:0]   dnoise_q;
  logic [DW-1:0]   dfilter_q;
  logic [DW-1:0]   qprev_q;
  logic [15:0]     lfsr_state;
  logic [15:0]     lfsr_nxt;

  logic signed [DW-1:0] noise_s;
  logic signed [DW:0]   sum_s;
  logic signed [DW-1:0] avg_s;
  logic signed [DW-1:0] filt_s;

  assign tick = (div_q == DIV_LAST);

  // sample divider and registered write strobe
  always_ff @(posedge m_clk or negedge sclr_n) begin
    if (!sclr_n) begin
      div_q       <= '0;
      sample_en_q <= 1'b0;
    end else begin
      sample_en_q <= tick;
      div_q       <= tick ? '0 : div_q + DIVW'(1);
    end
  end

  // pluck latch; a pluck while muted is dropped
  always_ff @(posedge m_clk or negedge sclr_n) begin
    if (!sclr_n) begin
      pend_q <= 1'b0;
    end else if (tick) begin
      pend_q <= 1'b0;
    end else if (pluck && !mute) begin
      pend_q <= 1'b1;
    end
  end

  assign pend_now = pend_q | (pluck & ~mute);

  // next state; mute overrides everything
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      mute: state_d = IDLE;
      !mute && state_q == IDLE && pend_now:
        state_d = BURST;
      !mute && state_q == BURST && cnt_q == CNT_LAST:
        state_d = RING;
      !mute && state_q == RING && pend_now:
        state_d = BURST;
      default: ;
    endcase
  end

  // FSM state, burst counter and registered flags
  always_ff @(posedge m_clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (tick) begin
      state_q   <= state_d;
      trigger_q <= (state_d == BURST);
      busy_q    <= (state_d != IDLE);
      if (state_d == BURST && state_q == BURST) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  ks_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (m_clk),
    .rst_n   (sclr_n),
    .en_i    (tick),
    .state_o (lfsr_state)
  );

  assign lfsr_nxt = lfsr_step(lfsr_state);
  assign noise_s  = DW'($signed(lfsr_nxt));

  assign sum_s  = {q[DW-1], q} + {qprev_q[DW-1], qprev_q};
  assign avg_s  = sum_s[DW:1];
  assign filt_s = avg_s - (avg_s >>> DECAY_SHIFT);

  // noise and feedback datapath, refreshed per sample
  always_ff @(posedge m_clk or negedge sclr_n) begin
    if (!sclr_n) begin
      dnoise_q  <= '0;
      dfilter_q <= '0;
      qprev_q   <= '0;
    end else if (tick) begin
      dnoise_q  <= noise_s >>> atten;
      dfilter_q <= (state_d == IDLE) ? '0 : filt_s;
      qprev_q   <= q;
    end
  end

  assign sample_en = sample_en_q;
  assign dnoise    = dnoise_q;
  assign dfilter   = dfilter_q;
  assign trigger   = trigger_q;
  assign busy      = busy_q;

endmodule

// File: doc/ks_pluck_ctrl.md
Name: ks_pluck_ctrl

Overview:
Excitation and feedback controller for the Karplus-Strong string delay line. It is the producing end of the delay-line interface: it consumes the line's tap output q and drives dnoise, dfilter and trigger. It also generates the per-sample write strobe, so the whole voice runs on the single m_clk domain. Per pluck, one noise burst is written for exactly one line length, then the damped two-tap average of q is fed back until the next pluck or a mute.

Parameters:
DW, 16, sample width; all samples are two's-complement signed.
DELAY_LEN, 328, length of the noise burst in samples; equals the delay-line length.
CLK_DIV, 1024, m_clk cycles per audio sample; must be at least 2.
DECAY_SHIFT, 8, feedback damping shift; gain is 1 - 2^-DECAY_SHIFT.
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1.

Ports:
m_clk  in  1  system clock; all logic is on its rising edge.
sclr_n  in  1  asynchronous, active-low reset.
pluck  in  1  pluck request; a single-cycle pulse is sufficient.
mute  in  1  level; while high, forces the voice silent.
atten  in  4  noise attenuation, applied as an arithmetic right shift of 0..15.
q  in  DW  delay-line tap output, signed.
sample_en  out  1  one-m_clk-wide write strobe, once per sample period.
dnoise  out  DW  attenuated noise sample.
dfilter  out  DW  damped feedback sample.
trigger  out  1  1 selects dnoise into the line; 0 selects dfilter.
busy  out  1  high while in BURST or RING.

Behaviour:
- Reset (sclr_n=0, asynchronous): state=IDLE; sample_en=0, dnoise=0, dfilter=0, trigger=0, busy=0; divider=0, burst counter=0, q_prev=0, pend=0; lfsr=LFSR_SEED (or 16'hACE1 if the seed is 0). Reset asserted mid-burst aborts the burst immediately.
- Divider: counts 0..CLK_DIV-1 and wraps to 0.
  - sample_en is registered and is high for the cycle after the divider reaches CLK_DIV-1.
  - Strobe period is exactly CLK_DIV cycles.
  - First strobe occurs CLK_DIV cycles after reset release.
- Every state, counter and datapath update happens only on tick cycles (divider==CLK_DIV-1), so outputs are stable whenever sample_en is high.
- Pluck capture: pluck sets pend on any cycle; pend clears on the tick that consumes it.
- FSM, evaluated on each tick; mute has priority over every other transition:
  - mute=1: go to IDLE, clear pend, trigger=0, busy=0.
  - IDLE: if pend, go to BURST, burst counter=0, trigger=1, busy=1.
  - BURST: burst counter increments each tick. When the counter reaches DELAY_LEN-1, go to RING and set trigger=0. trigger is therefore high for exactly DELAY_LEN strobes. pend is ignored and cleared in BURST.
  - RING: if pend, restart BURST with counter=0. Otherwise stay in RING.
- LFSR: 16-bit Galois, right-shifting, tap mask 16'hB400. Advances every tick in all states.
  - Next value = (lfsr>>1) XOR (lsb ? 16'hB400 : 0). It never reaches 0.
  - dnoise = (lfsr as signed) >>> atten, registered on each tick.
- Feedback filter, registered on each tick:
  - sum = sext17(q) + sext17(q_prev); avg = sum >>> 1, truncated to 16 bits (no overflow possible); dfilter = avg - (avg >>> DECAY_SHIFT); then q_prev = q.
  - In IDLE, dfilter=0 so the line drains to silence.
  - All shifts are arithmetic.
- Simultaneous pluck and mute: mute wins and the pluck is dropped.
- Pluck on the tick cycle itself: it is consumed at that same tick.

Decomposition:
- Shared package ks_pkg holds:
  - the state enum {IDLE, BURST, RING};
  - LFSR_TAPS = 16'hB400;
  - DEFAULT_SEED = 16'hACE1;
  - the DW default.
- One natural sub-module: ks_lfsr16 (enable, seed, 16-bit state output).
- The divider, FSM and filter stay in the top level.

Test Plan:
- CLK_DIV=4: release reset and hold 20 cycles -> all outputs 0 during reset; sample_en pulses one cycle wide, first at cycle 4, then every 4 cycles.
- Reset only, atten=0 -> successive LFSR/dnoise values on ticks are 0xE270, 0x7138, 0x389C; atten=4 on value 0xE270 -> dnoise=0xFE27.
- Pluck pulse in IDLE, DELAY_LEN=328 -> trigger rises at the next tick, stays high for exactly 328 strobes, then state is RING with busy=1.
- In RING with q held at 1000 -> dfilter=997 after the second tick; with q held at -1000 -> dfilter=-996 (16'hFC1C).
- mute=1 mid-burst -> trigger=0, busy=0, dfilter=0 at the next tick; pluck in the same cycle as mute -> no burst; pluck during BURST -> burst length still 328.
- Pluck during RING -> burst restarts, trigger high for another 328 strobes; sclr_n low mid-burst -> outputs 0 asynchronously, before any clock edge.
